// File: rtl/vending_pkg.sv
// Shared types and constants for the vending change dispenser.
// Coin values are expressed in nickel units (5 cents).
package vending_pkg;

    typedef enum logic [2:0] {
        CHG_0  = 3'd0,
        CHG_5  = 3'd1,
        CHG_10 = 3'd2,
        CHG_15 = 3'd3,
        CHG_20 = 3'd4
    } chg_e;

    localparam logic [2:0] NICKEL_U = 3'd1;
    localparam logic [2:0] DIME_U   = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        SODA,
        SELECT,
        EJECT
    } disp_state_e;

endpackage

// File: rtl/coin_tube_counter.sv
// Saturating up/down coin tube inventory counter.
// Simultaneous inc and dec leave the count unchanged.
module coin_tube_counter
    import vending_pkg::*;
#(
    parameter int DEPTH = 15,
    parameter int W     = 4
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_count_nxt
);

    localparam logic [W-1:0] MAX = W'(DEPTH);

    always_comb begin
        o_count_nxt = o_count;
        if (i_inc && !i_dec && o_count != MAX)
            o_count_nxt = o_count + W'(1);
        else if (i_dec && !i_inc && o_count != '0)
            o_count_nxt = o_count - W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            o_count <= '0;
        else
            o_count <= o_count_nxt;
    end

endmodule

// File: rtl/vending_change_dispenser.sv
// Sequences soda release and greedy coin change with req/ack actuators.
// Optional ack timeout: define VEND_DISP_TIMEOUT_EN.
module vending_change_dispenser
    import vending_pkg::*;
#(
    parameter int TUBE_DEPTH  = 15,
    parameter int CNT_W       = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_vend,
    input  logic [2:0]       i_change,
    output logic             o_busy,
    output logic             o_soda_req,
    input  logic             i_soda_ack,
    output logic             o_eject_nickel,
    output logic             o_eject_dime,
    input  logic             i_eject_ack,
    input  logic             i_refill_nickel,
    input  logic             i_refill_dime,
    output logic [CNT_W-1:0] o_nickel_cnt,
    output logic [CNT_W-1:0] o_dime_cnt,
    output logic             o_exact_change,
    input  logic             i_fault_clr,
    output logic             o_fault,
    output logic             o_overrun
);

    disp_state_e      state, state_nxt;
    logic [2:0]       rem, rem_nxt;
    logic             sel_dime, sel_dime_nxt;
    logic             fault_set;
    logic             overrun_set;
    logic             n_dec, d_dec;
    logic [CNT_W-1:0] n_nxt, d_nxt;
    logic             exact_nxt;
    logic             tmo;

    assign o_busy         = (state != IDLE);
    assign o_soda_req     = (state == SODA);
    assign o_eject_nickel = (state == EJECT) && !sel_dime;
    assign o_eject_dime   = (state == EJECT) && sel_dime;

`ifdef VEND_DISP_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          any_req;
    logic          any_ack;

    assign any_req = o_soda_req | o_eject_nickel | o_eject_dime;
    assign any_ack = (o_soda_req & i_soda_ack)
                   | ((o_eject_nickel | o_eject_dime) & i_eject_ack);
    assign tmo     = any_req && !any_ack
                   && (tmo_cnt == TW'(ACK_TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            tmo_cnt <= '0;
        else if (any_req && !any_ack && !tmo)
            tmo_cnt <= tmo_cnt + TW'(1);
        else
            tmo_cnt <= '0;
    end
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (ACK_TIMEOUT != 0);
    assign tmo            = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        rem_nxt      = rem;
        sel_dime_nxt = sel_dime;
        fault_set    = 1'b0;
        n_dec        = 1'b0;
        d_dec        = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_vend) begin
                    state_nxt = SODA;
                    if (i_change <= 3'(CHG_20)) begin
                        rem_nxt = i_change;
                    end else begin
                        rem_nxt   = 3'd0;
                        fault_set = 1'b1;
                    end
                end
            end
            SODA: begin
                if (i_soda_ack) begin
                    state_nxt = SELECT;
                end else if (tmo) begin
                    state_nxt = IDLE;
                    rem_nxt   = 3'd0;
                    fault_set = 1'b1;
                end
            end
            SELECT: begin
                if (rem == 3'd0) begin
                    state_nxt = IDLE;
                end else if (rem >= DIME_U && o_dime_cnt != '0) begin
                    sel_dime_nxt = 1'b1;
                    state_nxt    = EJECT;
                end else if (o_nickel_cnt != '0) begin
                    sel_dime_nxt = 1'b0;
                    state_nxt    = EJECT;
                end else begin
                    // Short-change: the owed amount is abandoned.
                    fault_set = 1'b1;
                    rem_nxt   = 3'd0;
                    state_nxt = IDLE;
                end
            end
            EJECT: begin
                if (i_eject_ack) begin
                    state_nxt = SELECT;
                    if (sel_dime) begin
                        d_dec   = 1'b1;
                        rem_nxt = rem - DIME_U;
                    end else begin
                        n_dec   = 1'b1;
                        rem_nxt = rem - NICKEL_U;
                    end
                end else if (tmo) begin
                    state_nxt = IDLE;
                    rem_nxt   = 3'd0;
                    fault_set = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign overrun_set = i_vend && (state != IDLE);

    assign exact_nxt = !((d_nxt >= CNT_W'(2))
                      || (d_nxt >= CNT_W'(1) && n_nxt >= CNT_W'(2))
                      || (n_nxt >= CNT_W'(4)));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state          <= IDLE;
            rem            <= 3'd0;
            sel_dime       <= 1'b0;
            o_fault        <= 1'b0;
            o_overrun      <= 1'b0;
            o_exact_change <= 1'b1;
        end else begin
            state          <= state_nxt;
            rem            <= rem_nxt;
            sel_dime       <= sel_dime_nxt;
            o_fault        <= fault_set | (o_fault & ~i_fault_clr);
            o_overrun      <= overrun_set | (o_overrun & ~i_fault_clr);
            o_exact_change <= exact_nxt;
        end
    end

    coin_tube_counter #(
        .DEPTH (TUBE_DEPTH),
        .W     (CNT_W)
    ) u_nickel (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_inc       (i_refill_nickel),
        .i_dec       (n_dec),
        .o_count     (o_nickel_cnt),
        .o_count_nxt (n_nxt)
    );

    coin_tube_counter #(
        .DEPTH (TUBE_DEPTH),
        .W     (CNT_W)
    ) u_dime (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_inc       (i_refill_dime),
        .i_dec       (d_dec),
        .o_count     (o_dime_cnt),
        .o_count_nxt (d_nxt)
    );

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Scoreboard bench for vending_change_dispenser: a cents-level model
// queues expected actuator events, a monitor pops them as the DUT acts.
module tb_vending_change_dispenser;

`ifdef VEND_DISP_TIMEOUT_EN
    localparam int TB_TMO = 8;
`else
    localparam int TB_TMO = 255;
`endif

    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic       i_vend = 1'b0;
    logic [2:0] i_change = 3'd0;
    logic       o_busy;
    logic       o_soda_req;
    logic       i_soda_ack = 1'b0;
    logic       o_eject_nickel;
    logic       o_eject_dime;
    logic       i_eject_ack = 1'b0;
    logic       i_refill_nickel;
    logic       i_refill_dime = 1'b0;
    logic [3:0] o_nickel_cnt;
    logic [3:0] o_dime_cnt;
    logic       o_exact_change;
    logic       i_fault_clr = 1'b0;
    logic       o_fault;
    logic       o_overrun;

    logic refill_n_stim = 1'b0;
    logic refill_n_resp = 1'b0;
    assign i_refill_nickel = refill_n_stim | refill_n_resp;

    always #5 i_clk = ~i_clk;

    vending_change_dispenser #(
        .TUBE_DEPTH  (15),
        .CNT_W       (4),
        .ACK_TIMEOUT (TB_TMO)
    ) dut (
        .i_clk           (i_clk),
        .i_rstn          (i_rstn),
        .i_vend          (i_vend),
        .i_change        (i_change),
        .o_busy          (o_busy),
        .o_soda_req      (o_soda_req),
        .i_soda_ack      (i_soda_ack),
        .o_eject_nickel  (o_eject_nickel),
        .o_eject_dime    (o_eject_dime),
        .i_eject_ack     (i_eject_ack),
        .i_refill_nickel (i_refill_nickel),
        .i_refill_dime   (i_refill_dime),
        .o_nickel_cnt    (o_nickel_cnt),
        .o_dime_cnt      (o_dime_cnt),
        .o_exact_change  (o_exact_change),
        .i_fault_clr     (i_fault_clr),
        .o_fault         (o_fault),
        .o_overrun       (o_overrun)
    );

    // kind: 0 soda, 1 nickel, 2 dime, 3 transaction done
    typedef struct {
        int kind;
        int n;
        int d;
        int fault;
        int overrun;
        int exact;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;

    int m_n = 0;
    int m_d = 0;
    int m_fault = 0;
    int m_overrun = 0;

    bit hold_soda = 0;
    bit hold_eject = 0;
    bit refill_with_ack = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int model_exact();
        return (m_d >= 2 || (m_d >= 1 && m_n >= 2) || m_n >= 4) ? 0 : 1;
    endfunction

    function automatic exp_t ev(input int kind);
        exp_t e;
        e.kind = kind;
        e.n = m_n;
        e.d = m_d;
        e.fault = m_fault;
        e.overrun = m_overrun;
        e.exact = model_exact();
        return e;
    endfunction

    // Acks arrive after a short random delay; stray eject acks are injected.
    initial begin : responder
        int w;
        int lim;
        w = 0;
        lim = 0;
        forever begin
            @(posedge i_clk);
            #1;
            i_soda_ack = 1'b0;
            i_eject_ack = 1'b0;
            refill_n_resp = 1'b0;
            if (o_soda_req && !hold_soda) begin
                if (w >= lim) begin
                    i_soda_ack = 1'b1;
                    w = 0;
                    lim = $urandom_range(0, 4);
                end else begin
                    w++;
                end
            end else if ((o_eject_nickel || o_eject_dime) && !hold_eject) begin
                if (w >= lim) begin
                    i_eject_ack = 1'b1;
                    if (refill_with_ack && o_eject_nickel)
                        refill_n_resp = 1'b1;
                    w = 0;
                    lim = $urandom_range(0, 4);
                end else begin
                    w++;
                end
            end else if (!o_eject_nickel && !o_eject_dime
                         && $urandom_range(0, 7) == 0) begin
                i_eject_ack = 1'b1;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        int   kind;
        bit   prev_busy;
        prev_busy = 0;
        forever begin
            @(negedge i_clk);
            if (!i_rstn) begin
                prev_busy = 0;
                continue;
            end
            if (o_eject_nickel && o_eject_dime)
                check("one_eject_req", 1, 0);
            kind = -1;
            if (o_soda_req && i_soda_ack)
                kind = 0;
            else if (o_eject_nickel && i_eject_ack)
                kind = 1;
            else if (o_eject_dime && i_eject_ack)
                kind = 2;
            if (prev_busy && !o_busy)
                kind = 3;
            if (kind >= 0) begin
                if (q.size() == 0) begin
                    check("unexpected_event", kind, 99);
                end else begin
                    e = q.pop_front();
                    check("event_kind", kind, e.kind);
                    if (kind == 3) begin
                        check("nickel_cnt", o_nickel_cnt, e.n);
                        check("dime_cnt", o_dime_cnt, e.d);
                        check("fault", o_fault, e.fault);
                        check("overrun", o_overrun, e.overrun);
                        check("exact_change", o_exact_change, e.exact);
                    end
                end
            end
            prev_busy = o_busy;
        end
    end

    task automatic do_reset();
        i_rstn = 1'b0;
        q.delete();
        m_n = 0;
        m_d = 0;
        m_fault = 0;
        m_overrun = 0;
        tick();
        tick();
        i_rstn = 1'b1;
        tick();
    endtask

    task automatic refill(input int nn, input int dd);
        int k;
        k = (nn > dd) ? nn : dd;
        for (int i = 0; i < k; i++) begin
            refill_n_stim = (i < nn);
            i_refill_dime = (i < dd);
            if (i < nn && m_n < 15) m_n++;
            if (i < dd && m_d < 15) m_d++;
            tick();
        end
        refill_n_stim = 1'b0;
        i_refill_dime = 1'b0;
    endtask

    task automatic clear_flags();
        i_fault_clr = 1'b1;
        tick();
        i_fault_clr = 1'b0;
        m_fault = 0;
        m_overrun = 0;
        check("fault_after_clr", o_fault, 0);
        check("overrun_after_clr", o_overrun, 0);
    endtask

    // Greedy change in cents: dime while 10c owed and dimes left, else nickel.
    task automatic vend(input int code, input bit ovr);
        int  cents;
        bit  done;
        cents = (code <= 4) ? code * 5 : 0;
        if (code > 4) m_fault = 1;
        if (ovr) m_overrun = 1;
        q.push_back(ev(0));
        while (cents > 0) begin
            if (cents >= 10 && m_d > 0) begin
                m_d--;
                cents -= 10;
                q.push_back(ev(2));
            end else if (m_n > 0) begin
                m_n--;
                cents -= 5;
                if (refill_with_ack && m_n < 15) m_n++;
                q.push_back(ev(1));
            end else begin
                m_fault = 1;
                cents = 0;
            end
        end
        q.push_back(ev(3));
        i_change = 3'(code);
        i_vend = 1'b1;
        tick();
        i_vend = 1'b0;
        if (ovr) begin
            tick();
            i_change = 3'($urandom_range(0, 7));
            i_vend = 1'b1;
            tick();
            i_vend = 1'b0;
        end
        done = 0;
        for (int i = 0; i < 300; i++) begin
            if (!o_busy) begin
                done = 1;
                break;
            end
            tick();
        end
        if (!done) check("vend_completes", 0, 1);
        tick();
    endtask

    initial begin : stimulus
        int cyc;
        bit seen;
        tick();
        tick();
        check("rst_busy", o_busy, 0);
        check("rst_soda_req", o_soda_req, 0);
        check("rst_eject_n", o_eject_nickel, 0);
        check("rst_eject_d", o_eject_dime, 0);
        check("rst_fault", o_fault, 0);
        check("rst_overrun", o_overrun, 0);
        check("rst_nickel", o_nickel_cnt, 0);
        check("rst_dime", o_dime_cnt, 0);
        check("rst_exact", o_exact_change, 1);
        i_rstn = 1'b1;
        tick();

        // 20c from 3 dimes / 2 nickels
        refill(2, 3);
        vend(4, 0);

        // 15c owed with a single nickel: short-change
        do_reset();
        refill(1, 0);
        vend(3, 0);

        // vend while busy sets overrun; clear drops it
        refill(3, 2);
        clear_flags();
        vend(2, 1);
        check("overrun_set", o_overrun, 1);
        clear_flags();

        // refill on nickel ack at count 5, then saturation at 15
        do_reset();
        refill(5, 0);
        refill_with_ack = 1;
        vend(1, 0);
        refill_with_ack = 0;
        refill(12, 0);
        check("nickel_sat", o_nickel_cnt, 15);
        refill(1, 0);
        check("nickel_sat_hold", o_nickel_cnt, 15);

        // reserved change code
        clear_flags();
        vend(6, 0);

        for (int t = 0; t < 40; t++) begin
            int code;
            clear_flags();
            refill($urandom_range(0, 3), $urandom_range(0, 2));
            code = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7)
                                               : $urandom_range(0, 4);
            vend(code, ($urandom_range(0, 3) == 0));
        end

        // reset while waiting on an eject ack
        do_reset();
        refill(2, 0);
        hold_eject = 1;
        q.push_back(ev(0));
        i_change = 3'd1;
        i_vend = 1'b1;
        tick();
        i_vend = 1'b0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (o_eject_nickel) begin
                seen = 1;
                break;
            end
            tick();
        end
        check("reached_eject", seen, 1);
        #2;
        i_rstn = 1'b0;
        #1;
        check("rst_mid_eject_n", o_eject_nickel, 0);
        check("rst_mid_busy", o_busy, 0);
        hold_eject = 0;
        do_reset();

`ifdef VEND_DISP_TIMEOUT_EN
        hold_soda = 1;
        clear_flags();
        i_change = 3'd0;
        i_vend = 1'b1;
        tick();
        i_vend = 1'b0;
        cyc = 0;
        for (int i = 0; i < 50; i++) begin
            if (!o_soda_req) break;
            cyc++;
            tick();
        end
        check("tmo_req_cycles", cyc, TB_TMO);
        check("tmo_fault", o_fault, 1);
        check("tmo_idle", o_busy, 0);
        hold_soda = 0;
        clear_flags();
`else
        cyc = 0;
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
